// File: rtl/rca_pkg.sv
// rca_pkg: shared types and constants for the nibble-serial adder.
//   state_e : controller state encoding (IDLE / ADD / DONE)
//   NIB_W   : width of one adder step (the rca operand width)
package rca_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADD  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int NIB_W = 4;

endpackage

// File: rtl/rca.sv
// rca: 4-bit ripple-carry adder, the shared datapath slice.
//   a, b  : nibble operands
//   c_in  : carry-in
//   sum   : {carry-out, 4-bit sum}
module rca (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       c_in,
  output logic [4:0] sum
);

  logic [4:0] c;

  assign c[0] = c_in;

  for (genvar i = 0; i < 4; i++) begin : g_fa
    assign sum[i]  = a[i] ^ b[i] ^ c[i];
    assign c[i+1]  = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign sum[4] = c[4];

endmodule

// File: rtl/rca_seq_ctrl.sv
// rca_seq_ctrl: WIDTH-bit adder built by stepping one 4-bit rca over the
// operands LSB nibble first, carrying between steps through a register.
//   clk, rst_n : clock, async active-low reset
//   start      : request, accepted in IDLE or DONE
//   a, b, c_in : operands, captured with an accepted start
//   busy       : nibble steps in progress
//   done       : one-cycle completion pulse
//   sum        : registered WIDTH+1 result, updated only on completion
module rca_seq_ctrl
  import rca_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH:0]   sum
);

  localparam int NIBS  = WIDTH / NIB_W;
  localparam int IDX_W = (NIBS > 1) ? $clog2(NIBS) : 1;

  state_e                       state_q, state_d;
  logic [NIBS-1:0][NIB_W-1:0]   a_q, a_d;
  logic [NIBS-1:0][NIB_W-1:0]   b_q, b_d;
  logic [NIBS-1:0][NIB_W-1:0]   work_q, work_d;
  logic [NIBS-1:0][NIB_W-1:0]   work_upd;
  logic                         carry_q, carry_d;
  logic [IDX_W-1:0]             idx_q, idx_d;
  logic [WIDTH:0]               sum_q, sum_d;

  logic [NIB_W-1:0]             rca_a, rca_b;
  logic [NIB_W:0]               rca_sum;
  logic                         last_nib;
  logic                         accept;

  // Adder sees registered values only, so its inputs are stable for the
  // whole cycle regardless of what the requester does with a/b/c_in.
  assign rca_a    = a_q[idx_q];
  assign rca_b    = b_q[idx_q];
  assign last_nib = (idx_q == IDX_W'(NIBS - 1));

  rca u_rca (
    .a    (rca_a),
    .b    (rca_b),
    .c_in (carry_q),
    .sum  (rca_sum)
  );

  // Work nibbles with the current step folded in; used both for the work
  // register and for the final sum load so the last nibble is not lost.
  always_comb begin
    work_upd        = work_q;
    work_upd[idx_q] = rca_sum[NIB_W-1:0];
  end

  // DONE accepts a new request too, giving back-to-back operation.
  assign accept = start && (state_q != ST_ADD);

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    work_d  = work_q;
    carry_d = carry_q;
    idx_d   = idx_q;
    sum_d   = sum_q;
    case (state_q)
      ST_ADD: begin
        work_d  = work_upd;
        carry_d = rca_sum[NIB_W];
        idx_d   = idx_q + IDX_W'(1);
        if (last_nib) begin
          state_d = ST_DONE;
          sum_d   = {rca_sum[NIB_W], work_upd};
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (accept) begin
      a_d     = a;
      b_d     = b;
      carry_d = c_in;
      idx_d   = '0;
      state_d = ST_ADD;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      work_q  <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      sum_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      work_q  <= work_d;
      carry_q <= carry_d;
      idx_q   <= idx_d;
      sum_q   <= sum_d;
    end
  end

  assign busy = (state_q == ST_ADD);
  assign done = (state_q == ST_DONE);
  assign sum  = sum_q;

endmodule

// File: tb/tb_rca_seq_ctrl.sv
// tb_rca_seq_ctrl: scoreboard bench for rca_seq_ctrl (WIDTH=16).
module tb_rca_seq_ctrl;

  localparam int WIDTH = 16;

  logic             clk   = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic             c_in  = 1'b0;
  logic [WIDTH-1:0] a     = '0;
  logic [WIDTH-1:0] b     = '0;
  logic             busy, done;
  logic [WIDTH:0]   sum;

  int               n_cmp    = 0;
  int               n_err    = 0;
  int               done_cnt = 0;
  logic [WIDTH:0]   exp_q[$];

  rca_seq_ctrl #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .c_in  (c_in),
    .busy  (busy),
    .done  (done),
    .sum   (sum)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic logic [WIDTH:0] model(input logic [WIDTH-1:0] av,
                                           input logic [WIDTH-1:0] bv,
                                           input logic cv);
    return {1'b0, av} + {1'b0, bv} + {{WIDTH{1'b0}}, cv};
  endfunction

  // Scoreboard consumer: every done pulse pops one expected sum.
  always @(negedge clk) begin
    logic [WIDTH:0] e;
    if (rst_n && done === 1'b1) begin
      done_cnt++;
      if (exp_q.size() == 0) chk("unexp_done", 32'd1, 32'd0);
      else begin
        e = exp_q.pop_front();
        chk("sum", 32'(sum), 32'(e));
      end
    end
  end

  task automatic issue(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv, input logic cv);
    a = av; b = bv; c_in = cv; start = 1'b1;
    exp_q.push_back(model(av, bv, cv));
  endtask

  // Full operation with busy/done timing checks; returns in the done cycle.
  task automatic do_op(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv, input logic cv);
    @(negedge clk);
    issue(av, bv, cv);
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("busy", 32'(busy), 32'd1);
      chk("done_early", 32'(done), 32'd0);
      @(negedge clk);
    end
    chk("done", 32'(done), 32'd1);
    chk("busy_in_done", 32'(busy), 32'd0);
  endtask

  initial begin
    int c0;
    int k;

    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_sum",  32'(sum),  32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // carry out of the top nibble
    do_op(16'hFFFF, 16'h0001, 1'b0);
    @(negedge clk);
    chk("done_1cyc", 32'(done), 32'd0);
    chk("sum_10000", 32'(sum), 32'h10000);

    // sum holds while inputs wiggle
    do_op(16'h1234, 16'h4321, 1'b1);
    @(negedge clk);
    chk("done_1cyc_b", 32'(done), 32'd0);
    for (int i = 0; i < 3; i++) begin
      a = 16'($urandom); b = 16'($urandom); c_in = ~c_in;
      @(negedge clk);
      chk("sum_hold", 32'(sum), 32'h05556);
    end

    // full ripple
    do_op(16'hFFFF, 16'hFFFF, 1'b1);
    @(negedge clk);
    chk("sum_wrap", 32'(sum), 32'h1FFFF);

    // start during ADD is ignored
    c0 = done_cnt;
    @(negedge clk);
    issue(16'h0F0F, 16'h00F1, 1'b0);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    a = 16'h5555; b = 16'hAAAA; c_in = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);
    chk("one_done", 32'(done_cnt - c0), 32'd1);
    chk("sum_ign", 32'(sum), 32'h01000);
    chk("idle_after_ign", 32'(busy), 32'd0);

    // back-to-back via start held in DONE
    @(negedge clk);
    issue(16'h0010, 16'h0020, 1'b0);
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    chk("b2b_done1", 32'(done), 32'd1);
    issue(16'h0001, 16'h0001, 1'b0);
    @(negedge clk);
    chk("b2b_no_gap", 32'(busy), 32'd1);
    start = 1'b0;
    k = 1;
    while (done !== 1'b1 && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("b2b_spacing", 32'(k), 32'd5);
    @(negedge clk);
    chk("sum_b2b", 32'(sum), 32'h00002);

    // reset mid-operation
    c0 = done_cnt;
    @(negedge clk);
    issue(16'h00FF, 16'h0101, 1'b0);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_done", 32'(done), 32'd0);
    chk("arst_sum",  32'(sum),  32'd0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    chk("no_done_after_rst", 32'(done_cnt - c0), 32'd0);
    chk("sum_after_rst", 32'(sum), 32'd0);
    do_op(16'h00FF, 16'h0101, 1'b0);
    @(negedge clk);
    chk("sum_post_rst", 32'(sum), 32'h00200);

    // a few random operands
    for (int i = 0; i < 6; i++)
      do_op(16'($urandom), 16'($urandom), 1'($urandom));
    @(negedge clk);
    chk("sb_empty", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
